// File: rtl/cmd_parser.sv
// Command packet parser behind the vGPU command FIFO: header decode, payload pass-through.
// Optional trailing XOR checksum per legal packet when CMD_PARSER_CHKSUM_EN is defined.
module cmd_parser #(
    parameter int DSIZE = 32,
    parameter int LEN_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DSIZE-1:0] fifo_rdata,
    input  logic             fifo_rempty,
    output logic             fifo_rinc,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic [7:0]       cmd_opcode,
    output logic [LEN_W-1:0] cmd_len,
    output logic             pl_valid,
    input  logic             pl_ready,
    output logic [DSIZE-1:0] pl_data,
    output logic             pl_last,
    output logic             err_opcode,
    output logic [CNT_W-1:0] cmd_count,
    output logic             busy
`ifdef CMD_PARSER_CHKSUM_EN
    ,
    output logic             err_chksum
`endif
);

`ifdef CMD_PARSER_CHKSUM_EN
    typedef enum logic [1:0] {S_HDR = 2'd0, S_CMD = 2'd1, S_PL = 2'd2, S_CHK = 2'd3} state_t;
    localparam state_t S_DONE = S_CHK;
`else
    typedef enum logic [1:0] {S_HDR = 2'd0, S_CMD = 2'd1, S_PL = 2'd2} state_t;
    localparam state_t S_DONE = S_HDR;
`endif

    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_ILL = 8'hFF;

    state_t             state_r;
    state_t             state_s;
    logic [7:0]         opcode_r;
    logic [LEN_W-1:0]   len_r;
    logic [LEN_W-1:0]   remain_r;
    logic               err_opcode_r;
    logic [CNT_W-1:0]   count_r;
    logic               rinc_s;
    logic               pl_valid_s;
    logic               hdr_pop_s;
    logic               cmd_hs_s;
    logic               pl_hs_s;
    logic [7:0]         head_op_s;

    assign head_op_s = fifo_rdata[31:24];

    // Next-state and handshake decode
    always_comb begin
        state_s    = state_r;
        rinc_s     = 1'b0;
        pl_valid_s = 1'b0;
        hdr_pop_s  = 1'b0;
        cmd_hs_s   = 1'b0;
        pl_hs_s    = 1'b0;
        case (state_r)
            S_HDR: begin
                rinc_s    = !fifo_rempty;
                hdr_pop_s = !fifo_rempty;
                if (!fifo_rempty && head_op_s != OP_NOP && head_op_s != OP_ILL) begin
                    state_s = S_CMD;
                end else begin
                    state_s = S_HDR;
                end
            end
            S_CMD: begin
                if (cmd_ready) begin
                    cmd_hs_s = 1'b1;
                    state_s  = (len_r == {LEN_W{1'b0}}) ? S_DONE : S_PL;
                end else begin
                    state_s = S_CMD;
                end
            end
            S_PL: begin
                pl_valid_s = !fifo_rempty;
                pl_hs_s    = !fifo_rempty && pl_ready;
                rinc_s     = pl_hs_s;
                if (pl_hs_s && remain_r == LEN_W'(1)) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_PL;
                end
            end
`ifdef CMD_PARSER_CHKSUM_EN
            S_CHK: begin
                rinc_s = !fifo_rempty;
                if (!fifo_rempty) begin
                    state_s = S_HDR;
                end else begin
                    state_s = S_CHK;
                end
            end
`endif
            default: begin
                state_s = S_HDR;
            end
        endcase
    end

    // State, header fields, payload countdown, accepted-command counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= S_HDR;
            opcode_r     <= 8'h00;
            len_r        <= {LEN_W{1'b0}};
            remain_r     <= {LEN_W{1'b0}};
            err_opcode_r <= 1'b0;
            count_r      <= {CNT_W{1'b0}};
        end else begin
            state_r      <= state_s;
            err_opcode_r <= hdr_pop_s && (head_op_s == OP_ILL);
            if (hdr_pop_s) begin
                opcode_r <= head_op_s;
                len_r    <= fifo_rdata[LEN_W-1:0];
            end
            if (cmd_hs_s) begin
                count_r  <= count_r + CNT_W'(1);
                remain_r <= len_r;
            end else if (pl_hs_s) begin
                remain_r <= remain_r - LEN_W'(1);
            end
        end
    end

`ifdef CMD_PARSER_CHKSUM_EN
    function automatic logic [DSIZE-1:0] xor_acc(input logic [DSIZE-1:0] acc,
                                                 input logic [DSIZE-1:0] word);
        return acc ^ word;
    endfunction

    logic [DSIZE-1:0] xor_r;
    logic             err_chksum_r;

    // Running XOR over the packet and trailer comparison
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xor_r        <= {DSIZE{1'b0}};
            err_chksum_r <= 1'b0;
        end else begin
            if (hdr_pop_s) begin
                xor_r <= fifo_rdata;
            end else if (pl_hs_s) begin
                xor_r <= xor_acc(xor_r, fifo_rdata);
            end
            err_chksum_r <= (state_r == S_CHK) && !fifo_rempty && (fifo_rdata != xor_r);
        end
    end

    assign err_chksum = err_chksum_r;
`endif

    // Header pops in idle are masked while reset is held so nothing leaves the FIFO
    assign fifo_rinc  = rinc_s && !rst;
    assign cmd_valid  = (state_r == S_CMD);
    assign cmd_opcode = opcode_r;
    assign cmd_len    = len_r;
    assign pl_valid   = pl_valid_s;
    assign pl_data    = fifo_rdata;
    assign pl_last    = pl_valid_s && (remain_r == LEN_W'(1));
    assign err_opcode = err_opcode_r;
    assign cmd_count  = count_r;
    assign busy       = (state_r != S_HDR);

endmodule

// File: tb/tb_cmd_parser.sv
// Bench for cmd_parser (default build): FIFO modelled as a queue, expected traffic
// derived per packet from the header rules, randomized packets and handshakes.
module tb_cmd_parser;
    localparam int DSIZE = 32;
    localparam int LEN_W = 4;
    localparam int CNT_W = 10;

    logic             clk = 1'b0;
    logic             rst;
    logic [DSIZE-1:0] fifo_rdata;
    logic             fifo_rempty;
    logic             fifo_rinc;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [7:0]       cmd_opcode;
    logic [LEN_W-1:0] cmd_len;
    logic             pl_valid;
    logic             pl_ready;
    logic [DSIZE-1:0] pl_data;
    logic             pl_last;
    logic             err_opcode;
    logic [CNT_W-1:0] cmd_count;
    logic             busy;

    int checks = 0;
    int failures = 0;

    logic [31:0] fifo_q[$];
    logic [11:0] exp_cmd[$];
    logic [11:0] obs_cmd[$];
    logic [32:0] exp_pl[$];
    logic [32:0] obs_pl[$];
    int exp_err = 0;
    int obs_err = 0;
    int pend_len = 0;
    int total_cmds = 0;

    cmd_parser #(.DSIZE(DSIZE), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .fifo_rdata(fifo_rdata), .fifo_rempty(fifo_rempty), .fifo_rinc(fifo_rinc),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_len(cmd_len),
        .pl_valid(pl_valid), .pl_ready(pl_ready), .pl_data(pl_data), .pl_last(pl_last),
        .err_opcode(err_opcode), .cmd_count(cmd_count), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic refresh();
        fifo_rempty = (fifo_q.size() == 0);
        fifo_rdata  = fifo_rempty ? 32'hDEADBEEF : fifo_q[0];
    endtask

    task automatic fpush(input logic [31:0] w);
        fifo_q.push_back(w);
        refresh();
    endtask

    // Expected effect of a header word: NOP vanishes, 0xFF flags an error, others are commands
    task automatic send_hdr(input logic [31:0] h);
        if (h[31:24] == 8'hFF) begin
            exp_err++;
        end else if (h[31:24] != 8'h00) begin
            exp_cmd.push_back({h[31:24], h[3:0]});
            total_cmds++;
            pend_len = int'(h[3:0]);
        end
        fpush(h);
    endtask

    task automatic send_pl(input logic [31:0] w);
        pend_len--;
        exp_pl.push_back({pend_len == 0, w});
        fpush(w);
    endtask

    // One clock: optional random ready, observe handshakes just before the edge, apply the pop
    task automatic tick(input bit rnd);
        logic p;
        if (rnd) begin
            cmd_ready = 1'($urandom_range(0, 1));
            pl_ready  = 1'($urandom_range(0, 1));
        end
        #1;
        p = fifo_rinc;
        chk("rinc_while_empty", {63'd0, p & fifo_rempty}, 64'd0);
        if (cmd_valid && cmd_ready) obs_cmd.push_back({cmd_opcode, cmd_len});
        if (pl_valid && pl_ready) obs_pl.push_back({pl_last, pl_data});
        if (err_opcode) obs_err++;
        @(posedge clk);
        if (p && fifo_q.size() != 0) void'(fifo_q.pop_front());
        #1;
        refresh();
    endtask

    task automatic drain(input bit rnd, input int budget);
        int n;
        n = 0;
        while ((fifo_q.size() != 0 || busy) && n < budget) begin
            tick(rnd);
            n++;
        end
        chk("drain_timeout", {63'd0, n < budget}, 64'd1);
        tick(1'b0);
        tick(1'b0);
    endtask

    task automatic compare(input string tag);
        chk({tag, "_ncmd"}, 64'(obs_cmd.size()), 64'(exp_cmd.size()));
        for (int i = 0; i < obs_cmd.size() && i < exp_cmd.size(); i++)
            chk({tag, "_cmd"}, 64'(obs_cmd[i]), 64'(exp_cmd[i]));
        chk({tag, "_npl"}, 64'(obs_pl.size()), 64'(exp_pl.size()));
        for (int i = 0; i < obs_pl.size() && i < exp_pl.size(); i++)
            chk({tag, "_pl"}, 64'(obs_pl[i]), 64'(exp_pl[i]));
        chk({tag, "_err"}, 64'(obs_err), 64'(exp_err));
        chk({tag, "_count"}, 64'(cmd_count), 64'(total_cmds % (1 << CNT_W)));
        obs_cmd.delete(); exp_cmd.delete(); obs_pl.delete(); exp_pl.delete();
        obs_err = 0; exp_err = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, {62'd0, cmd_valid, pl_valid}, 64'd0);
        chk({tag, "_flags"}, {60'd0, pl_last, fifo_rinc, err_opcode, busy}, 64'd0);
        chk({tag, "_count"}, 64'(cmd_count), 64'd0);
        chk({tag, "_fields"}, {52'd0, cmd_opcode, cmd_len}, 64'd0);
    endtask

    initial begin
        logic [31:0] h;
        int need;
        rst = 1'b1;
        cmd_ready = 1'b0;
        pl_ready = 1'b0;
        refresh();
        #2;
        chk_all_zero("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        // Basic packet
        cmd_ready = 1'b1;
        pl_ready = 1'b1;
        send_hdr(32'h12000003);
        send_pl(32'hA); send_pl(32'hB); send_pl(32'hC);
        tick(1'b0);
        chk("basic_latency", {52'd0, cmd_valid, busy, cmd_opcode, cmd_len}, {52'd0, 2'b11, 8'h12, 4'd3});
        drain(1'b0, 100);
        compare("basic");

        // NOP, illegal, zero-length command
        send_hdr(32'h00000005);
        send_hdr(32'hFF000002);
        send_hdr(32'h34000000);
        drain(1'b0, 100);
        compare("nop_ill");

        // Header backpressure, then payload underflow
        cmd_ready = 1'b0;
        send_hdr(32'h56000002);
        send_pl(32'h111);
        tick(1'b0);
        for (int i = 0; i < 10; i++) begin
            tick(1'b0);
            chk("hold_cmd", {51'd0, cmd_valid, cmd_opcode, cmd_len}, {51'd0, 1'b1, 8'h56, 4'd2});
        end
        cmd_ready = 1'b1;
        tick(1'b0);
        tick(1'b0);
        for (int i = 0; i < 5; i++) begin
            tick(1'b0);
            chk("underflow", {62'd0, pl_valid, busy}, {62'd0, 1'b0, 1'b1});
        end
        send_pl(32'h222);
        drain(1'b0, 100);
        compare("bp");

        // Reset in the middle of a payload with three words left
        pl_ready = 1'b0;
        send_hdr(32'h77000005);
        for (int i = 0; i < 5; i++) send_pl(32'h700 + 32'(i));
        tick(1'b0);
        tick(1'b0);
        pl_ready = 1'b1;
        tick(1'b0);
        tick(1'b0);
        pl_ready = 1'b0;
        #1;
        chk("mid_pl", {62'd0, pl_valid, pl_last}, {62'd0, 1'b1, 1'b0});
        rst = 1'b1;
        #1;
        chk_all_zero("rst_mid");
        #1 rst = 1'b0;
        fifo_q.delete();
        refresh();
        obs_cmd.delete(); exp_cmd.delete(); obs_pl.delete(); exp_pl.delete();
        obs_err = 0; exp_err = 0; total_cmds = 0; pend_len = 0;
        tick(1'b0);
        chk("after_rst", {62'd0, busy, fifo_rinc}, 64'd0);

        // Randomized packets with random handshakes
        for (int p = 0; p < 40; p++) begin
            int kind;
            kind = $urandom_range(0, 9);
            h = $urandom;
            if (kind == 0) begin
                h[31:24] = 8'h00;
                send_hdr(h);
            end else if (kind == 1) begin
                h[31:24] = 8'hFF;
                send_hdr(h);
            end else begin
                h[31:24] = 8'($urandom_range(1, 254));
                send_hdr(h);
                for (int k = 0; k < int'(h[3:0]); k++) send_pl($urandom);
            end
        end
        drain(1'b1, 5000);
        compare("random");

        // Counter wrap
        cmd_ready = 1'b1;
        pl_ready = 1'b1;
        need = ((1 << CNT_W) - 1) - (total_cmds % (1 << CNT_W));
        for (int i = 0; i < need; i++) send_hdr(32'h5A000000);
        drain(1'b0, 5000);
        chk("count_full", 64'(cmd_count), 64'((1 << CNT_W) - 1));
        compare("wrap_pre");
        send_hdr(32'h5B000000);
        drain(1'b0, 100);
        chk("count_wrap", 64'(cmd_count), 64'd0);
        compare("wrap");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
